// File: rtl/word_fetch_stream_pkg.sv
// Shared constants for the word fetch stream: state encodings, default widths
// and the buffer occupancy step helper.
package word_fetch_stream_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    function automatic logic [1:0] occ_step(input logic [1:0] occ, input logic push, input logic pop);
        return occ + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/word_fetch_stream_skid.sv
// Two-entry FIFO capturing ROM words; head is registered and holds its last value when empty.
// Push lands in the buffer next cycle; caller must not push when full or pop when empty.
module fetch_skid_buffer
    import word_fetch_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            occ <= occ_step(occ, push, pop);
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                end
                2'b01: begin
                    // Popping the last entry leaves head untouched so out_data holds.
                    if (occ == 2'd2) head <= tail;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/word_fetch_stream.sv
// Fetch stage walking base..base+count-1 through a combinational ROM into a 2-entry skid buffer.
// First word valid 2 cycles after start; issue stalls while the buffer is full. Loop mode: FETCH_LOOP_EN.
module word_fetch_stream
    import word_fetch_stream_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FETCH_LOOP_EN
    input  logic              stop,
`endif
    output logic              busy,
    output logic              done
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] index, index_nxt;
    logic [ADDR_W-1:0] remaining, remaining_nxt;
    logic [1:0]        occ, occ_nxt;
    logic              issue, pop;

`ifdef FETCH_LOOP_EN
    logic [ADDR_W-1:0] base_q, count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            count_q <= '0;
        end else if (state == ST_IDLE && start) begin
            base_q  <= base;
            count_q <= count;
        end
    end
`endif

    // Issue depends only on registered state, never on out_ready.
    assign issue     = (state == ST_RUN) && (remaining != '0) && (occ != 2'd2);
    assign pop       = out_valid && out_ready;
    assign out_valid = (occ != 2'd0);
    assign occ_nxt   = occ_step(occ, issue, pop);
    assign mem_addr  = index;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_comb begin
        state_nxt     = state;
        index_nxt     = index;
        remaining_nxt = remaining;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_nxt     = ST_RUN;
                        index_nxt     = base;
                        remaining_nxt = count;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    index_nxt     = index + ADDR_W'(1);
                    remaining_nxt = remaining - ADDR_W'(1);
                    if (remaining == ADDR_W'(1)) begin
`ifdef FETCH_LOOP_EN
                        index_nxt     = base_q;
                        remaining_nxt = count_q;
`else
                        state_nxt = ST_DRAIN;
`endif
                    end
                end
`ifdef FETCH_LOOP_EN
                if (stop) state_nxt = ST_DRAIN;
`endif
            end
            ST_DRAIN: begin
                if (occ_nxt == 2'd0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            index     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            remaining <= remaining_nxt;
        end
    end

    fetch_skid_buffer #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_data (mem_data),
        .pop       (pop),
        .occ       (occ),
        .head      (out_data)
    );

endmodule

// File: tb/tb_word_fetch_stream.sv
// Self-checking bench for word_fetch_stream: timing scenarios plus randomized runs
// scored against an expected-word queue built from base/count.
module tb_word_fetch_stream;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [29:0] base, count, mem_addr;
    logic [31:0] mem_data, out_data;
    logic        out_valid, busy, done;
`ifdef FETCH_LOOP_EN
    logic        stop = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [29:0] a);
        return {a[13:0], a[29:12]} ^ 32'hC3A5_5A3C;
    endfunction

    assign mem_data = rom(mem_addr);

    word_fetch_stream dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FETCH_LOOP_EN
        .stop      (stop),
`endif
        .busy      (busy),
        .done      (done)
    );

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; base = '0; count = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, busy, done} !== 3'b000 || mem_addr !== 30'd0 || out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: valid/busy/done=%b%b%b addr=%h data=%h required 000/0/0",
                     out_valid, busy, done, mem_addr, out_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Full-rate run with out_ready high; optional second start in cycle 1 must be ignored.
    task automatic test_stream(input logic [29:0] b, input logic [29:0] n, input bit restart);
        logic [29:0] a;
        logic        ev;
        start = 1'b1; base = b; count = n; out_ready = 1'b1;
        for (int c = 1; c <= int'(n) + 3; c++) begin
            @(negedge clk);
            if (c == 1 && restart) begin
                start = 1'b1; base = b + 30'd5; count = n + 30'd2;
            end else begin
                start = 1'b0;
            end
            ev = (c >= 2) && (c <= int'(n) + 1);
            vectors++;
            if (out_valid !== ev || busy !== (c <= int'(n) + 2) || done !== (c == int'(n) + 2)) begin
                miscompares++;
                $display("FAIL stream_ctl b=%h c=%0d: valid/busy/done=%b%b%b required %b%b%b",
                         b, c, out_valid, busy, done, ev, c <= int'(n) + 2, c == int'(n) + 2);
            end
            if (ev) begin
                a = b + 30'(c - 2);
                vectors++;
                if (out_data !== rom(a)) begin
                    miscompares++;
                    $display("FAIL stream_data b=%h c=%0d: got %h required %h", b, c, out_data, rom(a));
                end
            end
            if (c <= int'(n)) begin
                a = b + 30'(c - 1);
                vectors++;
                if (mem_addr !== a) begin
                    miscompares++;
                    $display("FAIL stream_addr b=%h c=%0d: got %h required %h", b, c, mem_addr, a);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        int          got, c;
        bit          seen_done;
        for (int i = 0; i < 4; i++) exp_q.push_back(rom(30'h10 + 30'(i)));
        start = 1'b1; base = 30'h10; count = 30'd4; out_ready = 1'b0;
        got = 0; seen_done = 1'b0; c = 0;
        while (!seen_done && c < 60) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (c >= 3 && c <= 6) begin
                vectors++;
                if (mem_addr !== 30'h12) begin
                    miscompares++;
                    $display("FAIL bp_freeze c=%0d: addr %h required 00000012", c, mem_addr);
                end
            end
            if (done) seen_done = 1'b1;
            out_ready = (c >= 7);
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL bp_order c=%0d: got %h required %h", c, out_data,
                             exp_q.size() ? exp_q[0] : 32'hx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
        end
        vectors++;
        if (got != 4 || !seen_done) begin
            miscompares++;
            $display("FAIL bp_count: words %0d done %0d required 4 and 1", got, seen_done);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        start = 1'b1; base = 30'h77; count = 30'd0; out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (out_valid !== 1'b0 || done !== (c == 1) || busy !== (c == 1)) begin
                miscompares++;
                $display("FAIL zero_count c=%0d: valid/busy/done=%b%b%b required 0%b%b",
                         c, out_valid, busy, done, c == 1, c == 1);
            end
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; base = 30'h80; count = 30'd8; out_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) begin
                vectors++;
                if ({out_valid, busy, done} !== 3'b000 || mem_addr !== 30'd0 || out_data !== 32'd0) begin
                    miscompares++;
                    $display("FAIL midrun_reset: valid/busy/done=%b%b%b addr=%h data=%h required 000/0/0",
                             out_valid, busy, done, mem_addr, out_data);
                end
            end else if (c > 4) begin
                vectors++;
                if (done !== 1'b0 || out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrun_quiet c=%0d: done=%b valid=%b required 0 0", c, done, out_valid);
                end
            end
            reset = (c == 3);
        end
        test_stream(30'h80, 30'd8, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [29:0] b, n;
        int          c, dones;
        bit          fin;
        for (int run = 0; run < 12; run++) begin
            b = (run % 3 == 0) ? 30'h3FFFFFF8 + 30'($urandom_range(0, 7)) : 30'($urandom);
            n = 30'($urandom_range(0, 10));
            exp_q.delete();
            for (int i = 0; i < int'(n); i++) exp_q.push_back(rom(b + 30'(i)));
            start = 1'b1; base = b; count = n; out_ready = 1'b0;
            c = 0; dones = 0; fin = 1'b0;
            while (!fin && c < 300) begin
                @(negedge clk);
                c++;
                start = 1'b0;
                if (dones != 0) begin
                    fin = 1'b1;
                    vectors++;
                    if (busy !== 1'b0 || done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rand_after_done run=%0d: busy=%b done=%b required 0 0", run, busy, done);
                    end
                end else if (done) begin
                    dones++;
                    vectors++;
                    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rand_early_done run=%0d: pending %0d valid=%b required 0 0",
                                 run, exp_q.size(), out_valid);
                    end
                end
                out_ready = ($urandom_range(0, 2) != 0);
                if (out_valid && out_ready) begin
                    vectors++;
                    if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL rand_data run=%0d: got %h required %h", run, out_data,
                                 exp_q.size() ? exp_q[0] : 32'hx);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            vectors++;
            if (!fin) begin
                miscompares++;
                $display("FAIL rand_timeout run=%0d: pending %0d dones %0d required completion", run, exp_q.size(), dones);
            end
        end
        out_ready = 1'b1;
    endtask

`ifdef FETCH_LOOP_EN
    task automatic test_loop();
        int  k;
        bit  fin;
        int  done_c;
        start = 1'b1; base = 30'd0; count = 30'd2; out_ready = 1'b1;
        k = 0; fin = 1'b0; done_c = 0;
        for (int c = 1; c <= 20 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop = (c == 6);
            if (done) begin
                done_c = c;
                fin = 1'b1;
            end
            if (out_valid) begin
                vectors++;
                if (out_data !== rom(30'(k % 2))) begin
                    miscompares++;
                    $display("FAIL loop_data k=%0d: got %h required %h", k, out_data, rom(30'(k % 2)));
                end
                k++;
            end
        end
        stop = 1'b0;
        vectors++;
        if (k != 6 || done_c != 8) begin
            miscompares++;
            $display("FAIL loop_stop: words %0d done cycle %0d required 6 and 8", k, done_c);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_stream(30'h10, 30'd4, 1'b0);
        test_backpressure();
        test_zero_count();
        test_stream(30'h40, 30'd3, 1'b1);
        test_stream(30'h3FFFFFFE, 30'd3, 1'b0);
        test_reset_midrun();
        test_random();
`ifdef FETCH_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/word_fetch_stream.md
# word_fetch_stream

Streaming fetch stage that sits directly upstream of the pipelined accumulator. It walks a word index from a programmed base for a programmed count and presents the index to a combinational-read word ROM. It captures each returned word into a 2-entry skid buffer and hands words downstream over a valid/ready handshake. It replaces the free-running counter-plus-ROM front end, so the consumer can stall without losing or repeating words.

## Interface

Parameters:
- ADDR_W, 30: word-index width; the index is byte address [31:2].
- DATA_W, 32: data word width.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle request to begin a run; honoured only in IDLE.
- base, input, ADDR_W: first word index; sampled on an accepted start.
- count, input, ADDR_W: number of words in the run; sampled on an accepted start.
- mem_addr, output, ADDR_W: word index driven to the ROM.
- mem_data, input, DATA_W: ROM read data for mem_addr, same cycle (combinational).
- out_data, output, DATA_W: head-of-buffer word.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts this cycle.
- busy, output, 1: state is not IDLE.
- done, output, 1: one-cycle pulse at the end of a run.
- stop, input, 1: present only with FETCH_LOOP_EN; see Configuration.

## Operation

- States:
  - IDLE: waits for start.
  - RUN: issues fetches.
  - DRAIN: all fetches issued; waits for the buffer to empty.
  - DONE: asserts done for one cycle.
- IDLE transitions:
  - start with count!=0: load index<=base and remaining<=count, go to RUN.
  - start with count==0: go to DONE directly.
  - start is ignored in every state other than IDLE.
- Issue rule: issue = (state==RUN) && (remaining!=0) && (occ<2).
  - occ is the registered buffer occupancy, 0..2.
  - No combinational path exists from out_ready to issue or mem_addr.
- On issue:
  - Push mem_data into the buffer.
  - Increment index modulo 2^ADDR_W (0x3FFFFFFF wraps to 0).
  - Decrement remaining.
- Pop occurs when out_valid && out_ready. The buffer is FIFO-ordered.
- Occupancy update: occ_next = occ + issue − pop. Simultaneous push and pop are legal at occ 1 or 2.
- RUN→DRAIN: in the cycle the last word issues (remaining goes 1→0).
- DRAIN→DONE: when occ_next==0.
- DONE→IDLE: always, after one cycle.
- out_valid = (occ!=0). When occ==0, out_data holds its last value.
- Output reset values:
  - mem_addr = 0, out_data = 0, out_valid = 0, busy = 0, done = 0.
  - State is IDLE and occ = 0.
- Reset mid-run: the buffer is flushed and in-flight words are discarded. All outputs take their reset values on the next edge, and no done pulse is generated.

## Timing

- An accepted start in cycle 0 puts the FSM in RUN in cycle 1, with mem_addr=base; the first issue happens in cycle 1.
- out_valid rises in cycle 2 with out_data=mem[base].
- Throughput: with out_ready held high, occ stays at 1 and one word is delivered per cycle.
  - A run of N words delivers its last word in cycle N+1.
  - done pulses in cycle N+2, and busy drops in cycle N+3.
- When out_ready is low, at most 2 words are buffered and issue halts. Issue resumes the cycle after a pop drops occ below 2.
- A count==0 start in cycle 0 gives done=1 in cycle 1 and out_valid is never raised.

## Configuration

- FETCH_LOOP_EN defined:
  - In RUN, the issue of the last word reloads index<=base and remaining<=count (the values latched at start). The FSM stays in RUN and the same words are streamed again.
  - The stop input is present. stop in RUN forces DRAIN on the next edge; words already buffered are still delivered, then DONE.
  - stop in any other state is ignored.
- FETCH_LOOP_EN undefined: single-pass behaviour as above, and the stop port does not exist.

## Structure

- State encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3) and the default widths go in the shared constants header, alongside the ALU opcode defines.
- The base and count latch registers use the common parameterised register module with enable.
- Sub-module fetch_skid_buffer: the 2-entry FIFO with push, pop, occ, head data and synchronous reset.
- The FSM, index counter and remaining counter stay in the top-level module.

## Test plan

- base=0x10, count=4, out_ready=1 held → out_data mem[0x10..0x13] in cycles 2–5, done in cycle 6, busy low in cycle 7.
- Same run with out_ready=0 for cycles 2–6 → occ saturates at 2 and mem_addr freezes at 0x12. The same 4 words arrive in order after release, with no duplicates.
- count=0 start → done in cycle 1, out_valid never asserted; start in cycle 1 of a run → ignored, sequence unchanged.
- base=0x3FFFFFFE, count=3 → mem_addr 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000.
- reset asserted in cycle 3 of an 8-word run → next cycle out_valid=0 and busy=0; no done pulse; a fresh start then works from base.
- FETCH_LOOP_EN: base=0, count=2, stop in cycle 6 → stream 0,1,0,1,…; words issued before stop drain, then done.
